// File: rtl/fp_pkg.sv
// Shared single-precision constants, unpacked-operand type and unpack helper.
// Denormal inputs unpack to a signed zero with no hidden bit.
package fp_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 2 * EXP_BIAS + 1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
  } fp_unpacked_t;

  function automatic fp_unpacked_t fp_unpack(input logic [FP_W-1:0] x);
    fp_unpacked_t u;
    u.sign = x[FP_W-1];
    u.exp  = x[FP_W-2:MAN_W];
    u.man  = (u.exp == '0) ? '0 : {1'b1, x[MAN_W-1:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc25.sv
// Combinational 25-bit leading-zero counter; an all-zero input reports 25.
// No state, no handshake.
module fp_lzc25 (
  input  logic [24:0] din,
  output logic [4:0]  cnt
);

  always_comb begin
    cnt = 5'd25;
    // Ascending scan: the highest set bit is the last one to write cnt.
    for (int i = 0; i < 25; i++) begin
      if (din[i]) cnt = 5'(24 - i);
    end
  end

endmodule

// File: rtl/fp_sub_pipe.sv
// 3-stage single-precision subtract/add (truncating, denormals flushed); result 3 cycles after accept.
// One global advance enable: any stall on the output freezes every stage and drops in_ready.
module fp_sub_pipe
  import fp_pkg::*;
#(
  parameter int NEGATE_B = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] operand_a,
  input  logic [FP_W-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] result
);

  // One guard bit below the mantissa plus one carry bit above the hidden 1.
  localparam int SUM_W = MAN_W + 3;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // S1: effective sign of b, then order by magnitude (ties keep a as the larger).
  fp_unpacked_t ua, ub, big_d, small_d;
  logic         a_ge_b;

  always_comb begin
    ua = fp_unpack(operand_a);
    ub = fp_unpack(operand_b);
    if (NEGATE_B != 0) ub.sign = ~ub.sign;
    a_ge_b  = {ua.exp, ua.man} >= {ub.exp, ub.man};
    big_d   = a_ge_b ? ua : ub;
    small_d = a_ge_b ? ub : ua;
  end

  logic         s1_vld;
  fp_unpacked_t s1_big, s1_small;

  // S2: align the smaller operand and add or subtract magnitudes.
  logic [EXP_W-1:0] exp_diff;
  logic [SUM_W-2:0] small_al;
  logic [SUM_W-1:0] big_al, sum_d;

  always_comb begin
    exp_diff = s1_big.exp - s1_small.exp;
    big_al   = {1'b0, s1_big.man, 1'b0};
    small_al = (exp_diff > 8'd24) ? '0 : ({s1_small.man, 1'b0} >> exp_diff);
    sum_d    = (s1_big.sign ^ s1_small.sign) ? big_al - {1'b0, small_al}
                                             : big_al + {1'b0, small_al};
  end

  logic             s2_vld;
  logic             s2_sign;
  logic             s2_inf;
  logic [EXP_W-1:0] s2_exp;
  logic [SUM_W-1:0] s2_sum;

  // S3: normalize, range-check the exponent and pack.
  logic [4:0]              lz;
  logic [EXP_W+1:0]        exp_inc;
  logic signed [EXP_W+1:0] exp_dec;
  logic [FP_W-1:0]         res_d;

  fp_lzc25 u_lzc (
    .din (s2_sum[SUM_W-2:0]),
    .cnt (lz)
  );

  always_comb begin
    exp_inc = {2'b00, s2_exp} + 10'd1;
    exp_dec = $signed({2'b00, s2_exp}) - $signed({5'b00000, lz});
    res_d   = '0;
    if (s2_inf) begin
      res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_sum == '0) begin
      res_d = '0;
    end else if (s2_sum[SUM_W-1]) begin
      if (exp_inc >= 10'(EXP_MAX)) res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else                         res_d = {s2_sign, exp_inc[EXP_W-1:0], s2_sum[SUM_W-2:2]};
    end else begin
      if (exp_dec <= 10'sd0) res_d = {s2_sign, {(FP_W-1){1'b0}}};
      else res_d = {s2_sign, exp_dec[EXP_W-1:0],
                    MAN_W'((s2_sum[SUM_W-2:0] << lz) >> 1)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_big    <= '0;
      s1_small  <= '0;
      s2_vld    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_inf    <= 1'b0;
      s2_exp    <= '0;
      s2_sum    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (en) begin
      s1_vld    <= in_valid;
      s1_big    <= big_d;
      s1_small  <= small_d;
      s2_vld    <= s1_vld;
      s2_sign   <= s1_big.sign;
      s2_inf    <= (s1_big.exp == EXP_W'(EXP_MAX));
      s2_exp    <= s1_big.exp;
      s2_sum    <= sum_d;
      out_valid <= s2_vld;
      result    <= res_d;
    end
  end

endmodule
